// File: rtl/mem_loader.sv
// Image loader: packs a little-endian byte stream into DATA_W-bit words and
// writes them to sequential addresses, flagging write_done after NUM_WORDS words.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for write to start a load
// COLLECT | accepting bytes into the assembled word
// WRITE   | one-cycle memory write strobe for the assembled word
// DONE    | full image written; hold write_done until write drops
module mem_loader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int NUM_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              write_done,
  output logic [ADDR_W:0]   word_count
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [ADDR_W:0]  LAST_WORD = (ADDR_W + 1)'(NUM_WORDS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        state;
  logic [IDX_W-1:0]  byte_idx;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] word_buf;
  logic [DATA_W-1:0] word_next;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // Shift-in from the top: after BYTES bytes the first one sits in the LSB.
  assign word_next = (word_buf >> 8) | (DATA_W'(byte_data) << (DATA_W - 8));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      byte_idx    <= '0;
      addr        <= '0;
      word_count  <= '0;
      word_buf    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (write) begin
            state      <= S_COLLECT;
            byte_idx   <= '0;
            addr       <= '0;
            word_count <= '0;
          end
        end
        S_COLLECT: begin
          if (!write) begin
            state <= S_IDLE;
          end else if (byte_valid) begin
            word_buf <= word_next;
            if (byte_idx == LAST_IDX) begin
              // Output registers capture the word so they hold after the strobe.
              mem_addr_q  <= addr;
              mem_wdata_q <= word_next;
              state       <= S_WRITE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        S_WRITE: begin
          addr       <= addr + 1'b1;
          word_count <= word_count + 1'b1;
          byte_idx   <= '0;
          if (!write)
            state <= S_IDLE;
          else if (word_count == LAST_WORD)
            state <= S_DONE;
          else
            state <= S_COLLECT;
        end
        S_DONE: begin
          if (!write)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign byte_ready = (state == S_COLLECT);
  assign mem_we     = (state == S_WRITE);
  assign write_done = (state == S_DONE);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a 4-word image; bytes are sent as an
// incrementing count so every written word has a hand-computable value.
module tb_mem_loader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int NWORDS = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              write;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              write_done;
  logic [ADDR_W:0]   word_count;

  int checks = 0;
  int passes = 0;
  int nb;
  int done_cyc;
  bit done;
  logic [63:0] wr_addr[$];
  logic [63:0] wr_data[$];
  int          wr_cyc[$];

  mem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WORDS(NWORDS)) dut (
    .clk(clk), .rst(rst), .write(write), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .write_done(write_done),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a load from IDLE; abort_at >= 0 drops write once that many bytes are in.
  task automatic run_load(input bit toggle, input int abort_at, input int budget);
    bit rdy_prev;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    nb = 0;
    done = 0;
    done_cyc = -1;
    rdy_prev = 0;
    write = 1'b1;
    byte_valid = 1'b0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("wc_start", word_count, 0);
      if (rdy_prev && byte_valid) nb++;
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
        wr_cyc.push_back(cyc);
        chk("ready_in_write", byte_ready, 0);
      end
      if (write_done) begin
        done = 1;
        done_cyc = cyc;
      end
      if (abort_at >= 0 && nb == abort_at) write = 1'b0;
      rdy_prev = byte_ready;
      byte_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      byte_data = nb[7:0];
    end
    byte_valid = 1'b0;
  endtask

  task automatic verify_image(input string tag);
    logic [31:0] e;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_nwr"}, wr_addr.size(), NWORDS);
    for (int i = 0; i < wr_addr.size() && i < NWORDS; i++) begin
      for (int k = 0; k < 4; k++) e[8*k +: 8] = 8'(4*i + k);
      chk({tag, "_addr"}, wr_addr[i], i);
      chk({tag, "_data"}, wr_data[i], e);
    end
    if (wr_cyc.size() == NWORDS)
      chk({tag, "_done_lat"}, done_cyc, wr_cyc[NWORDS-1] + 1);
    chk({tag, "_wc"}, word_count, NWORDS);
  endtask

  initial begin
    rst = 1'b1;
    write = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ready", byte_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_done", write_done, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wc", word_count, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", byte_ready, 0);
      chk("idle_we", mem_we, 0);
      chk("idle_done", write_done, 0);
      chk("idle_wc", word_count, 0);
    end

    // continuous stream
    run_load(0, -1, 60);
    verify_image("cont");
    for (int i = 1; i < wr_cyc.size(); i++)
      chk("cont_spacing", wr_cyc[i] - wr_cyc[i-1], 5);
    chk("cont_addr_hold", mem_addr, 3);
    chk("cont_data_hold", mem_wdata, 32'h0F0E0D0C);
    write = 1'b0;
    @(negedge clk);
    chk("cont_done_drop", write_done, 0);

    // byte_valid toggling, then linger in DONE
    run_load(1, -1, 100);
    verify_image("tog");
    byte_valid = 1'b1;
    byte_data = 8'hAA;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_done", write_done, 1);
      chk("hold_ready", byte_ready, 0);
      chk("hold_we", mem_we, 0);
    end
    chk("hold_wc", word_count, NWORDS);
    chk("hold_wdata", mem_wdata, 32'h0F0E0D0C);
    write = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    chk("hold_done_drop", write_done, 0);
    chk("idle_wc_kept", word_count, NWORDS);

    // abort after 6 bytes, then a full reload
    run_load(0, 6, 20);
    chk("abort_not_done", done, 0);
    chk("abort_nwr", wr_addr.size(), 1);
    if (wr_addr.size() > 0) begin
      chk("abort_addr", wr_addr[0], 0);
      chk("abort_data", wr_data[0], 32'h03020100);
    end
    chk("abort_idle", byte_ready, 0);
    run_load(0, -1, 60);
    verify_image("reload");
    write = 1'b0;
    @(negedge clk);

    // reset mid-word
    run_load(0, -1, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_ready", byte_ready, 0);
    chk("rstw_we", mem_we, 0);
    chk("rstw_done", write_done, 0);
    chk("rstw_addr", mem_addr, 0);
    chk("rstw_wdata", mem_wdata, 0);
    chk("rstw_wc", word_count, 0);
    rst = 1'b0;
    write = 1'b0;
    @(negedge clk);
    chk("rstw_idle", byte_ready, 0);

    // reset while in DONE with write still high
    run_load(0, -1, 60);
    chk("rstd_reached", done, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstd_done", write_done, 0);
    chk("rstd_we", mem_we, 0);
    chk("rstd_ready", byte_ready, 0);
    chk("rstd_addr", mem_addr, 0);
    chk("rstd_wdata", mem_wdata, 0);
    chk("rstd_wc", word_count, 0);
    rst = 1'b0;
    write = 1'b0;
    @(negedge clk);
    chk("rstd_idle_done", write_done, 0);
    chk("rstd_idle_ready", byte_ready, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Image-load stage that feeds the boot/run control FSM of the pipelined CPU.
- While the control FSM holds `write` high, it accepts a byte stream over a valid/ready handshake and packs the bytes little-endian into DATA_W-bit words.
- It writes each word to sequential memory addresses starting at 0.
- After NUM_WORDS words it raises `write_done`, which the control FSM requires before it enters run mode.

Parameters:
- DATA_W, 32, memory word width; must be a multiple of 8.
- ADDR_W, 10, memory address width.
- NUM_WORDS, 256, words per image; range 1..2^ADDR_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- write  in  1  load enable from the control FSM; level-sensitive.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  image byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  memory write strobe; one cycle per word.
- mem_addr  out  ADDR_W  word address for mem_we.
- mem_wdata  out  DATA_W  packed word for mem_we.
- write_done  out  1  full image written; level.
- word_count  out  ADDR_W+1  words written in the current load.

Behaviour:
Reset:
- rst=1 at a clock edge: state=IDLE, byte index=0, address=0, word_count=0, assembled word=0.
- Outputs after reset: byte_ready=0, mem_we=0, write_done=0, mem_addr=0, mem_wdata=0.
- rst overrides everything, including a load in progress.

Outputs (decoded from registered state; no input-to-output combinational path):
- byte_ready=1 only in COLLECT.
- mem_we=1 only in WRITE.
- write_done=1 only in DONE.

States:
- IDLE:
  - write=1 → COLLECT; clear byte index, address and word_count.
  - Otherwise stay in IDLE.
- COLLECT:
  - A byte is accepted on a cycle with byte_valid=1 (byte_ready=1 throughout).
  - Byte k of a word (k=0..DATA_W/8-1) lands in bits [8k+7:8k]; the first byte is the LSB.
  - Accepting the last byte of a word → WRITE.
  - byte_valid=0 → hold state; no change.
- WRITE:
  - mem_we=1 with mem_addr=current address and mem_wdata=assembled word.
  - Next cycle: address+1, word_count+1, byte index=0.
  - If the word just written was word NUM_WORDS-1 → DONE; else → COLLECT.
- DONE:
  - write_done=1 held while write=1.
  - write=0 → IDLE; write_done drops the following cycle.
  - word_count keeps its value until the next load starts.

Abort:
- write=0 in COLLECT → IDLE next cycle; the partial word is discarded and no mem_we is issued.
- write=0 in WRITE → that cycle's mem_we still occurs, then → IDLE.

Simultaneous events:
- write=0 and a byte handshake in the same COLLECT cycle: the byte is consumed but discarded.

Latency and widths:
- One byte per cycle maximum; each word takes DATA_W/8 accepting cycles plus one WRITE cycle, so 5 cycles per word at DATA_W=32.
- No byte is accepted during WRITE.
- The address never wraps within one load, since NUM_WORDS ≤ 2^ADDR_W.
- word_count reaches NUM_WORDS exactly, so it is ADDR_W+1 bits wide to represent 2^ADDR_W.
- mem_addr and mem_wdata hold their last written values outside WRITE.

Test Plan:
1. rst=1 for 2 cycles, then write=0 for 10 cycles → byte_ready=0, mem_we=0, write_done=0, word_count=0 throughout.
2. NUM_WORDS=4, write=1, continuous bytes 0x00..0x0F:
   - mem_we pulses 4 times, every 5th cycle, at addr 0..3 with data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
   - write_done=1 the cycle after the 4th mem_we; word_count=4.
3. Same as 2 with byte_valid toggling every other cycle → identical addr/data sequence; no byte lost or duplicated; byte_ready=0 during each WRITE cycle.
4. Drop write after 6 bytes accepted → exactly 1 mem_we (addr 0, 0x03020100) and return to IDLE. Reassert write and send a full image → writes restart at addr 0, word_count restarts at 0.
5. In DONE, hold write=1 for 20 cycles → write_done stays 1 and byte_valid is ignored. Then write=0 → write_done=0 one cycle later.
6. Assert rst mid-word and mid-DONE → next cycle all outputs at reset values, state=IDLE, no mem_we.
